// File: rtl/sprite_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_pkg : sprite VRAM geometry, op codes and writer FSM states    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sprite_pkg;

  localparam int SPRITE_SIZE  = 32;
  localparam int SPRITE_COUNT = 8;
  localparam int VRAM_A_WIDTH = 13;
  localparam int VRAM_D_WIDTH = 8;

  localparam int XY_W   = $clog2(SPRITE_SIZE);
  localparam int SLOT_W = $clog2(SPRITE_COUNT);

  localparam logic OP_LOAD = 1'b0;
  localparam logic OP_FILL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/sprite_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_addr_gen : raster x/y counters producing {slot, y, x} address |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sprite_addr_gen
  import sprite_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic [SLOT_W-1:0]       slot_i,
  input  logic                    advance_i,
  output logic [VRAM_A_WIDTH-1:0] addr_o,
  output logic                    last_o
);

  logic [SLOT_W-1:0] slot_q;
  logic [XY_W-1:0]   x_q;
  logic [XY_W-1:0]   y_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (clear_i) begin
      slot_q <= slot_i;
      x_q    <= '0;
      y_q    <= '0;
    end else if (advance_i) begin
      x_q <= x_q + 1'b1;
      if (&x_q) begin
        y_q <= y_q + 1'b1;
      end
    end
  end

  // Power-of-two geometry: the slot base is just the upper address bits.
  assign addr_o = {slot_q, y_q, x_q};
  assign last_o = (&x_q) && (&y_q);

endmodule
`default_nettype wire

// File: rtl/sprite_vram_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sprite_vram_writer : streams LOAD/FILL commands into sprite VRAM     |
// | Optional: CHECKSUM_EN adds a 16-bit sum of written bytes.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sprite_vram_writer
  import sprite_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_op,
  input  logic [3:0]              cmd_sprite,
  input  logic [VRAM_D_WIDTH-1:0] cmd_colour,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic [VRAM_D_WIDTH-1:0] pix_data,
  input  logic                    abort,
  output logic                    mem_write,
  output logic [VRAM_A_WIDTH-1:0] mem_addr,
  output logic [VRAM_D_WIDTH-1:0] mem_data,
  output logic                    busy,
  output logic                    done,
  output logic                    err
`ifdef CHECKSUM_EN
  ,
  output logic [15:0]             checksum
`endif
);

  state_e                  state_q, state_d;
  logic                    ready_q;
  logic [VRAM_D_WIDTH-1:0] colour_q;
  logic                    mem_write_q, mem_write_d;
  logic [VRAM_A_WIDTH-1:0] mem_addr_q;
  logic [VRAM_D_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                    err_q, err_d;

  logic                    gen_clear;
  logic                    gen_advance;
  logic [VRAM_A_WIDTH-1:0] gen_addr;
  logic                    gen_last;
  logic                    cmd_accept;
  logic                    slot_ok;

  assign cmd_accept = cmd_valid && cmd_ready;
  assign slot_ok    = ({28'd0, cmd_sprite} < 32'(SPRITE_COUNT));

  sprite_addr_gen u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (gen_clear),
    .slot_i    (cmd_sprite[SLOT_W-1:0]),
    .advance_i (gen_advance),
    .addr_o    (gen_addr),
    .last_o    (gen_last)
  );

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    pix_ready   = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    err_d       = 1'b0;
    gen_clear   = 1'b0;
    gen_advance = 1'b0;
    mem_write_d = 1'b0;
    mem_data_d  = mem_data_q;
    case (state_q)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = ready_q;
        if (cmd_accept) begin
          if (slot_ok) begin
            gen_clear = 1'b1;
            state_d   = (cmd_op == OP_FILL) ? FILL : LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        pix_ready = !abort;
        if (abort) begin
          state_d = IDLE;
        end else if (pix_valid) begin
          mem_write_d = 1'b1;
          mem_data_d  = pix_data;
          gen_advance = 1'b1;
          if (gen_last) state_d = DONE;
        end
      end
      FILL: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          mem_write_d = 1'b1;
          mem_data_d  = colour_q;
          gen_advance = 1'b1;
          if (gen_last) state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle still carries the final write; pulse once it has drained.
        if (!mem_write_q) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      colour_q    <= '0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= 1'b1;
      err_q       <= err_d;
      mem_write_q <= mem_write_d;
      if (mem_write_d) begin
        mem_addr_q <= gen_addr;
        mem_data_q <= mem_data_d;
      end
      if (gen_clear) begin
        colour_q <= cmd_colour;
      end
    end
  end

  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign err       = err_q;

`ifdef CHECKSUM_EN
  logic [15:0] checksum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (gen_clear) begin
      checksum_q <= '0;
    end else if (mem_write_d) begin
      checksum_q <= checksum_q + 16'(mem_data_d);
    end
  end

  assign checksum = checksum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_vram_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sprite_vram_writer : directed self-checking bench                 |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sprite_vram_writer;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [3:0]  cmd_sprite;
  logic [7:0]  cmd_colour;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_data;
  logic        abort;
  logic        mem_write;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;
  logic        err;
`ifdef CHECKSUM_EN
  logic [15:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  // Write log and event counters gathered at the inactive edge.
  logic [12:0] wa[$];
  logic [7:0]  wd[$];
  int          wcyc[$];
  int          cyc = 0;
  int          last_wcyc = 0;
  int          n_done = 0;
  int          done_cyc = 0;
  int          n_err = 0;
  int          n_busy = 0;
  int          n_pixrdy = 0;

  sprite_vram_writer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_sprite (cmd_sprite),
    .cmd_colour (cmd_colour),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .abort      (abort),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .busy       (busy),
    .done       (done),
    .err        (err)
`ifdef CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (mem_write) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
      wcyc.push_back(cyc);
      last_wcyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (err)       n_err++;
    if (busy)      n_busy++;
    if (pix_ready) n_pixrdy++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wcyc.delete();
    n_done   = 0;
    n_err    = 0;
    n_busy   = 0;
    n_pixrdy = 0;
  endtask

  task automatic send_cmd(input logic op, input logic [3:0] spr, input logic [7:0] col);
    int k;
    k = 0;
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_sprite = spr;
    cmd_colour = col;
    #1;
    while (!cmd_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (k >= 20) begin
      errors++;
      $display("FAIL cmd_accept_timeout: cmd_ready=%0b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drive_beats(input int n, input bit gappy, input int abort_at);
    int  i;
    int  guard;
    bit  tog;
    i = 0; guard = 0; tog = 1'b1;
    while (i < n && guard < 5000) begin
      pix_valid = gappy ? tog : 1'b1;
      pix_data  = 8'(i);
      abort     = (i == abort_at);
      #1;
      if (abort) begin
        @(posedge clk); #1;
        abort     = 1'b0;
        pix_valid = 1'b0;
        return;
      end
      if (pix_valid && pix_ready) i++;
      @(posedge clk); #1;
      tog = ~tog;
      guard++;
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (n_done == 0 && k < 3000) begin
      @(negedge clk); #1;
      k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({cmd_ready, pix_ready, mem_write, busy, done, err, mem_addr, mem_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b prdy=%b wr=%b busy=%b done=%b err=%b addr=%h data=%h required all 0",
               cmd_ready, pix_ready, mem_write, busy, done, err, mem_addr, mem_data);
    end
`ifdef CHECKSUM_EN
    checks++;
    if (checksum !== 16'h0000) begin
      errors++;
      $display("FAIL reset_checksum: got %h required 0000", checksum);
    end
`endif
    clear_log();
    reset = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_edge: cmd_ready=%b required 0", cmd_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_release: cmd_ready=%b busy=%b required 1/0", cmd_ready, busy);
    end
    checks++;
    if (wa.size() != 0) begin
      errors++;
      $display("FAIL reset_no_write: writes=%0d required 0", wa.size());
    end
  endtask

  task automatic test_load_streaming();
    int bad;
    clear_log();
    send_cmd(1'b0, 4'd2, 8'h00);
    drive_beats(1024, 1'b0, -1);
    wait_done();
    checks++;
    if (wa.size() != 1024) begin
      errors++;
      $display("FAIL load2_count: writes=%0d required 1024", wa.size());
    end
    bad = -1;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] !== 13'(2048 + i) || wd[i] !== 8'(i) || (i > 0 && wcyc[i] != wcyc[i-1] + 1)) begin
        bad = i;
        break;
      end
    end
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL load2_stream: idx %0d addr=%0d data=%h required addr=%0d data=%h back-to-back",
               bad, wa[bad], wd[bad], 2048 + bad, 8'(bad));
    end
    checks++;
    if (n_done != 1 || done_cyc != last_wcyc + 1) begin
      errors++;
      $display("FAIL load2_done: pulses=%0d at cycle %0d required 1 at cycle %0d", n_done, done_cyc, last_wcyc + 1);
    end
`ifdef CHECKSUM_EN
    checks++;
    if (checksum !== 16'hFE00) begin
      errors++;
      $display("FAIL load2_checksum: got %h required FE00", checksum);
    end
`endif
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL load2_ready_after: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_load_gaps();
    int bad;
    clear_log();
    send_cmd(1'b0, 4'd0, 8'h00);
    drive_beats(1024, 1'b1, -1);
    wait_done();
    checks++;
    if (wa.size() != 1024) begin
      errors++;
      $display("FAIL load0_count: writes=%0d required 1024", wa.size());
    end
    bad = -1;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] !== 13'(i) || wd[i] !== 8'(i) || (i > 0 && wcyc[i] != wcyc[i-1] + 2)) begin
        bad = i;
        break;
      end
    end
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL load0_gapped: idx %0d addr=%0d data=%h required addr=%0d data=%h every 2nd cycle",
               bad, wa[bad], wd[bad], bad, 8'(bad));
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL load0_done: pulses=%0d required 1", n_done);
    end
  endtask

  task automatic test_fill();
    int bad;
    clear_log();
    send_cmd(1'b1, 4'd7, 8'h3C);
    wait_done();
    checks++;
    if (wa.size() != 1024) begin
      errors++;
      $display("FAIL fill7_count: writes=%0d required 1024", wa.size());
    end
    bad = -1;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] !== 13'(7168 + i) || wd[i] !== 8'h3C || (i > 0 && wcyc[i] != wcyc[i-1] + 1)) begin
        bad = i;
        break;
      end
    end
    checks++;
    if (bad != -1) begin
      errors++;
      $display("FAIL fill7_stream: idx %0d addr=%0d data=%h required addr=%0d data=3c back-to-back",
               bad, wa[bad], wd[bad], 7168 + bad);
    end
    checks++;
    if (n_pixrdy != 0) begin
      errors++;
      $display("FAIL fill7_pix_ready: high for %0d cycles required 0", n_pixrdy);
    end
    checks++;
    if (n_done != 1 || done_cyc != last_wcyc + 1) begin
      errors++;
      $display("FAIL fill7_done: pulses=%0d at cycle %0d required 1 at cycle %0d", n_done, done_cyc, last_wcyc + 1);
    end
`ifdef CHECKSUM_EN
    checks++;
    if (checksum !== 16'hF000) begin
      errors++;
      $display("FAIL fill7_checksum: got %h required F000", checksum);
    end
`endif
  endtask

  task automatic test_bad_slot();
    clear_log();
    send_cmd(1'b0, 4'd9, 8'h00);
    abort = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b0;
    checks++;
    if (n_err != 1) begin
      errors++;
      $display("FAIL bad_slot_err: pulses=%0d required 1", n_err);
    end
    checks++;
    if (wa.size() != 0 || n_busy != 0) begin
      errors++;
      $display("FAIL bad_slot_quiet: writes=%0d busy_cycles=%0d required 0/0", wa.size(), n_busy);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_abort_ready: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_abort();
    clear_log();
    send_cmd(1'b0, 4'd1, 8'h00);
    drive_beats(1024, 1'b0, 100);
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: busy=%b cmd_ready=%b required 0/1", busy, cmd_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wa.size() != 100 || wa[wa.size()-1] !== 13'd1123 || wd[wd.size()-1] !== 8'd99) begin
      errors++;
      $display("FAIL abort_last_write: writes=%0d last addr=%0d data=%0d required 100/1123/99",
               wa.size(), wa[wa.size()-1], wd[wd.size()-1]);
    end
    checks++;
    if (n_done != 0) begin
      errors++;
      $display("FAIL abort_no_done: pulses=%0d required 0", n_done);
    end
    clear_log();
    send_cmd(1'b1, 4'd3, 8'hA5);
    wait_done();
    checks++;
    if (wa.size() != 1024 || wa[0] !== 13'd3072 || wd[0] !== 8'hA5 || n_done != 1) begin
      errors++;
      $display("FAIL after_abort_cmd: writes=%0d first addr=%0d data=%h done=%0d required 1024/3072/a5/1",
               wa.size(), wa[0], wd[0], n_done);
    end
  endtask

  task automatic test_reset_mid();
    send_cmd(1'b1, 4'd4, 8'h11);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (mem_write !== 1'b1) begin
      errors++;
      $display("FAIL mid_fill_writing: mem_write=%b required 1", mem_write);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: wr=%b busy=%b rdy=%b required 0/0/0", mem_write, busy, cmd_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || wa.size() != 0 || n_done != 0) begin
      errors++;
      $display("FAIL mid_reset_recover: rdy=%b writes=%0d done=%0d required 1/0/0", cmd_ready, wa.size(), n_done);
    end
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = 1'b0;
    cmd_sprite = 4'd0;
    cmd_colour = 8'h00;
    pix_valid  = 1'b0;
    pix_data   = 8'h00;
    abort      = 1'b0;
    test_reset();
    test_load_streaming();
    test_load_gaps();
    test_fill();
    test_bad_slot();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_vram_writer.md
Name: sprite_vram_writer

Overview:
Write-side engine for the sprite VRAM that the SVGA display path reads. It accepts load or fill commands for one sprite slot and streams a 32x32 sprite into the dual-use sram write port (i_write/i_addr/i_data), one byte per cycle. Sprite pixels are palette indices.
The block sits between the host/loader logic and the vram instance, so sprites can be replaced at run time instead of only through MEMFILE.

Parameters:
SPRITE_SIZE, 32, sprite edge in pixels (power of two)
SPRITE_COUNT, 8, number of sprite slots in VRAM
VRAM_A_WIDTH, 13, VRAM address width; must equal log2(SPRITE_SIZE*SPRITE_SIZE*SPRITE_COUNT)
VRAM_D_WIDTH, 8, palette-index width per pixel

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  1  0 = LOAD (stream pixels), 1 = FILL (constant colour)
cmd_sprite  in  4  target slot index
cmd_colour  in  VRAM_D_WIDTH  fill value (FILL only)
pix_valid  in  1  pixel byte offered
pix_ready  out  1  pixel accepted when pix_valid && pix_ready
pix_data  in  VRAM_D_WIDTH  pixel palette index
abort  in  1  cancel the current command
mem_write  out  1  VRAM write strobe
mem_addr  out  VRAM_A_WIDTH  VRAM write address
mem_data  out  VRAM_D_WIDTH  VRAM write data
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes
err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset: asynchronous and active-high. All outputs are 0 while reset is high. cmd_ready goes to 1 on the first clock edge after reset is released. The FSM enters IDLE.
- States are IDLE, LOAD, FILL and DONE.
- IDLE:
  - cmd_ready = 1, busy = 0.
  - On accept with cmd_sprite >= SPRITE_COUNT: err pulses on the next cycle and the FSM stays in IDLE. No write occurs.
  - On a valid accept: the slot is latched, the pixel counter is cleared, and the FSM moves to LOAD or FILL according to cmd_op.
- LOAD:
  - busy = 1, cmd_ready = 0, pix_ready = 1.
  - For each accepted beat, on the next cycle: mem_write = 1, mem_data = that beat's pix_data, mem_addr = slot*SPRITE_SIZE^2 + y*SPRITE_SIZE + x.
  - Registered latency is one cycle from beat to write.
  - Pixel order is raster: x increments fastest, y increments when x wraps at SPRITE_SIZE-1.
  - Cycles with no accepted beat produce mem_write = 0. Gaps are allowed.
- FILL:
  - pix_ready = 0.
  - Exactly one write per cycle of cmd_colour, to the same address sequence as LOAD.
  - SPRITE_SIZE^2 consecutive cycles in total.
- Completion:
  - After write index SPRITE_SIZE^2-1 (x = y = SPRITE_SIZE-1), the FSM enters DONE.
  - In DONE, done = 1 for one cycle, in the cycle after the last mem_write.
  - The FSM then returns to IDLE; cmd_ready is 1 in the following cycle.
  - The counter never wraps into the next slot.
- Address generation: because SPRITE_SIZE is a power of two, the address is the concatenation {slot, y, x}. No multiplier is used.
- abort:
  - In LOAD or FILL, abort takes priority over a simultaneous beat: that beat is not written and pix_ready drops.
  - The FSM returns to IDLE next cycle, with no done and no further mem_write.
  - Bytes already written stay in VRAM. In IDLE, abort has no effect.
- Reset mid-command behaves like abort. mem_write deasserts immediately, asynchronously.

Optional Feature:
CHECKSUM_EN
- Defined:
  - Adds output checksum[15:0], the modulo-2^16 sum of mem_data over every write of the current command.
  - The sum is cleared on command accept and is stable from the done pulse until the next accept.
  - Its reset value is 0.
- Undefined: the port and its adder are absent; all other behaviour is identical.

Decomposition:
- Shared package sprite_pkg holds:
  - SPRITE_SIZE, SPRITE_COUNT, VRAM_A_WIDTH, VRAM_D_WIDTH
  - the state enum (IDLE/LOAD/FILL/DONE)
  - the cmd_op encodings (OP_LOAD = 0, OP_FILL = 1)
- The display path reuses the same constants.
- One sub-module, sprite_addr_gen, contains the x/y counters with clear/advance, the last-pixel flag and the {slot, y, x} address.

Test Plan:
- Reset release: all outputs are 0 during reset; cmd_ready = 1 one cycle after release; no mem_write.
- LOAD slot 2 with 1024 beats of data i mod 256, pix_valid held high: addresses 2048..3071 in order, mem_data = i mod 256, one cycle per write, done exactly one cycle after the write to address 3071, then cmd_ready = 1.
- LOAD slot 0 with pix_valid toggling every other cycle: mem_write only in cycles after accepted beats; 1024 writes total, addresses 0..1023.
- FILL slot 7, colour 0x3C: 1024 back-to-back writes to 7168..8191 of 0x3C; pix_ready stays 0. With CHECKSUM_EN, checksum = 0xF000 at done.
- cmd_sprite = 9 accepted: err pulses once; no mem_write; busy stays 0.
- abort asserted together with beat 100 of a slot-1 LOAD: last write is to address 1123 (beat 99); that beat is not written; no done; busy = 0 next cycle; a new command is accepted afterwards.
